rf_write_scheduler: RTL and testbench

Shares the register file's single write port between two producers: the in-order pipeline writeback (primary, never stalled) and a multi-cycle/late-result unit (secondary, valid/ready). Secondary results that lose arbitration are held in a small in-order queue, and queued entries made stale by newer writeback writes are killed. A pending-register bitmap lets the hazard unit stall reads of queued destinations. The block sits between the writeback stage and the register file write inputs (RegWrite, rd, write_data).

---
 rtl/rf_sched_pkg.sv | 13 +
 rtl/rf_sched_fifo.sv | 71 +++++++
 rtl/rf_write_scheduler.sv | 127 ++++++++++++
 tb/tb_rf_write_scheduler.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/rf_sched_pkg.sv
// Shared types and constants for the register-file write scheduler.
package rf_sched_pkg;
    localparam int unsigned RF_ADDR_W = 5;
    localparam int unsigned NUM_REGS  = 32;
    localparam int unsigned RF_DATA_W = 32;

    // Queued secondary write; live drops to 0 when a newer writeback targets rd.
    typedef struct packed {
        logic                 live;
        logic [RF_ADDR_W-1:0] rd;
        logic [RF_DATA_W-1:0] data;
    } rf_wr_entry_t;
endpackage

// File: rtl/rf_sched_fifo.sv
// In-order queue of late secondary writes with kill-by-rd and a pending-register bitmap.
module rf_sched_fifo
    import rf_sched_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_push,
    input  rf_wr_entry_t         i_push_ent,
    input  logic                 i_pop,
    input  logic                 i_kill,
    input  logic [RF_ADDR_W-1:0] i_kill_rd,
    output rf_wr_entry_t         o_head,
    output logic                 o_empty,
    output logic                 o_full,
    output logic [NUM_REGS-1:0]  o_pending
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    rf_wr_entry_t       r_mem [DEPTH];
    logic [DEPTH-1:0]   r_vld;
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;
    logic [NUM_REGS-1:0] w_pending;

    function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_vld   <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_kill && r_mem[i].rd == i_kill_rd) r_mem[i].live <= 1'b0;
            end
            if (i_pop) begin
                r_vld[r_head] <= 1'b0;
                r_head        <= f_inc(r_head);
            end
            // Push only happens when not full, so the tail slot never aliases the head.
            if (i_push) begin
                r_mem[r_tail] <= i_push_ent;
                r_vld[r_tail] <= 1'b1;
                r_tail        <= f_inc(r_tail);
            end
            if (i_push && !i_pop)      r_count <= r_count + 1'b1;
            else if (!i_push && i_pop) r_count <= r_count - 1'b1;
        end
    end

    always_comb begin
        w_pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_vld[i] && r_mem[i].live) w_pending[r_mem[i].rd] = 1'b1;
        end
    end

    assign o_head    = r_mem[r_head];
    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_pending = w_pending;
endmodule

// File: rtl/rf_write_scheduler.sv
// Arbitrates the register-file write port between writeback and a late-result unit.
// Optional starvation stall is enabled by defining RF_SCHED_STALL_EN.
module rf_write_scheduler
    import rf_sched_pkg::*;
#(
    parameter int unsigned N            = 32,
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wb_valid,
    input  logic [RF_ADDR_W-1:0] wb_rd,
    input  logic [N-1:0]         wb_data,
    input  logic                 mc_valid,
    output logic                 mc_ready,
    input  logic [RF_ADDR_W-1:0] mc_rd,
    input  logic [N-1:0]         mc_data,
    output logic                 RegWrite,
    output logic [RF_ADDR_W-1:0] rd,
    output logic [N-1:0]         write_data,
    output logic [NUM_REGS-1:0]  pending,
    output logic                 wb_hold
);
    rf_wr_entry_t         w_head;
    rf_wr_entry_t         w_push_ent;
    logic                 w_empty, w_full;
    logic                 w_wb_go, w_mc_acc, w_bypass, w_push, w_pop;
    logic                 w_nxt_we;
    logic [RF_ADDR_W-1:0] w_nxt_rd;
    logic [N-1:0]         w_nxt_data;
    logic                 r_we;
    logic [RF_ADDR_W-1:0] r_rd;
    logic [N-1:0]         r_data;

    assign w_wb_go  = wb_valid && (wb_rd != '0);
    assign w_mc_acc = mc_valid && !w_full;
    assign w_bypass = !w_wb_go && w_empty && w_mc_acc;
    // An mc result for the register wb is overwriting this cycle is already stale.
    assign w_push   = w_mc_acc && (mc_rd != '0) && !w_bypass && !(w_wb_go && mc_rd == wb_rd);
    assign w_pop    = !w_wb_go && !w_empty;
    assign w_push_ent = '{live: 1'b1, rd: mc_rd, data: mc_data};

    always_comb begin
        w_nxt_we   = 1'b0;
        w_nxt_rd   = r_rd;
        w_nxt_data = r_data;
        if (w_wb_go) begin
            w_nxt_we   = 1'b1;
            w_nxt_rd   = wb_rd;
            w_nxt_data = wb_data;
        end else if (!w_empty) begin
            w_nxt_we   = w_head.live;
            w_nxt_rd   = w_head.rd;
            w_nxt_data = w_head.data;
        end else if (w_mc_acc && mc_rd != '0) begin
            w_nxt_we   = 1'b1;
            w_nxt_rd   = mc_rd;
            w_nxt_data = mc_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we   <= 1'b0;
            r_rd   <= '0;
            r_data <= '0;
        end else begin
            r_we <= w_nxt_we;
            if (w_nxt_we) begin
                r_rd   <= w_nxt_rd;
                r_data <= w_nxt_data;
            end
        end
    end

    rf_sched_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_push_ent (w_push_ent),
        .i_pop      (w_pop),
        .i_kill     (w_wb_go),
        .i_kill_rd  (wb_rd),
        .o_head     (w_head),
        .o_empty    (w_empty),
        .o_full     (w_full),
        .o_pending  (pending)
    );

`ifdef RF_SCHED_STALL_EN
    localparam int unsigned SC_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [SC_W-1:0] LIMIT = SC_W'(STARVE_LIMIT);

    logic [SC_W-1:0] r_starve;
    logic [SC_W-1:0] w_starve_inc;
    logic            r_wb_hold;
    logic            w_starved;

    assign w_starved    = w_wb_go && !w_empty && w_head.live;
    assign w_starve_inc = (r_starve == LIMIT) ? r_starve : r_starve + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starve  <= '0;
            r_wb_hold <= 1'b0;
        end else if (w_pop) begin
            r_starve  <= '0;
            r_wb_hold <= 1'b0;
        end else if (w_starved) begin
            r_starve <= w_starve_inc;
            if (w_starve_inc == LIMIT) r_wb_hold <= 1'b1;
        end
    end

    assign wb_hold = r_wb_hold;
`else
    assign wb_hold = 1'b0;
`endif

    assign mc_ready   = !w_full;
    assign RegWrite   = r_we;
    assign rd         = r_rd;
    assign write_data = r_data;
endmodule

// File: tb/tb_rf_write_scheduler.sv
// Self-checking bench for rf_write_scheduler: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_rf_write_scheduler;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned LIMIT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid, mc_valid, mc_ready, RegWrite, wb_hold;
    logic [4:0]  wb_rd, mc_rd, rd;
    logic [31:0] wb_data, mc_data, write_data;
    logic [31:0] pending;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit          live;
        logic [4:0]  rd;
        logic [31:0] data;
    } m_ent_t;

    m_ent_t      mq[$];
    logic        e_we = 1'b0;
    logic [4:0]  e_rd = '0;
    logic [31:0] e_data = '0;
    logic        e_hold = 1'b0;
    int          m_starve = 0;
    logic [31:0] d_rf [32];

    rf_write_scheduler #(
        .N            (32),
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .mc_valid   (mc_valid),
        .mc_ready   (mc_ready),
        .mc_rd      (mc_rd),
        .mc_data    (mc_data),
        .RegWrite   (RegWrite),
        .rd         (rd),
        .write_data (write_data),
        .pending    (pending),
        .wb_hold    (wb_hold)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_pending();
        logic [31:0] p = '0;
        foreach (mq[i]) if (mq[i].live) p[mq[i].rd] = 1'b1;
        return p;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".we"}, {31'd0, RegWrite}, {31'd0, e_we});
        if (e_we) begin
            chk({tag, ".rd"}, {27'd0, rd}, {27'd0, e_rd});
            chk({tag, ".data"}, write_data, e_data);
        end
        chk({tag, ".pending"}, pending, model_pending());
        chk({tag, ".ready"}, {31'd0, mc_ready}, {31'd0, (mq.size() < DEPTH)});
        chk({tag, ".hold"}, {31'd0, wb_hold}, {31'd0, e_hold});
        if (RegWrite === 1'b1) d_rf[rd] = write_data;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".we0"}, {31'd0, RegWrite}, 32'd0);
        chk({tag, ".rd0"}, {27'd0, rd}, 32'd0);
        chk({tag, ".data0"}, write_data, 32'd0);
        chk({tag, ".pend0"}, pending, 32'd0);
        chk({tag, ".ready1"}, {31'd0, mc_ready}, 32'd1);
        chk({tag, ".hold0"}, {31'd0, wb_hold}, 32'd0);
    endtask

    task automatic model_reset();
        mq.delete();
        e_we = 1'b0; e_rd = '0; e_data = '0; e_hold = 1'b0; m_starve = 0;
    endtask

    task automatic model_update(input logic wv, input logic [4:0] wr, input logic [31:0] wd,
                                input logic mv, input logic [4:0] mr, input logic [31:0] md);
        bit     acc, popped, starved;
        m_ent_t e;
        if (!rst) begin
            model_reset();
            return;
        end
        acc     = mv && (mq.size() < DEPTH);
        popped  = 1'b0;
        starved = 1'b0;
        if (wv && wr != 0) begin
            starved = (mq.size() > 0) && mq[0].live;
            foreach (mq[i]) if (mq[i].rd == wr) mq[i].live = 1'b0;
            e_we = 1'b1; e_rd = wr; e_data = wd;
            if (acc && mr != 0 && mr != wr) mq.push_back('{1'b1, mr, md});
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            popped = 1'b1;
            e_we = e.live;
            if (e.live) begin e_rd = e.rd; e_data = e.data; end
            if (acc && mr != 0) mq.push_back('{1'b1, mr, md});
        end else if (acc && mr != 0) begin
            e_we = 1'b1; e_rd = mr; e_data = md;
        end else begin
            e_we = 1'b0;
        end
`ifdef RF_SCHED_STALL_EN
        if (popped) begin
            m_starve = 0;
            e_hold   = 1'b0;
        end else if (starved) begin
            if (m_starve < LIMIT) m_starve++;
            if (m_starve == LIMIT) e_hold = 1'b1;
        end
`else
        if (popped || starved) m_starve = 0;
`endif
    endtask

    // One cycle: check state at negedge, drive inputs, advance model at posedge.
    task automatic step(input string tag,
                        input logic wv, input logic [4:0] wr, input logic [31:0] wd,
                        input logic mv, input logic [4:0] mr, input logic [31:0] md);
        check_all(tag);
        wb_valid = wv; wb_rd = wr; wb_data = wd;
        mc_valid = mv; mc_rd = mr; mc_data = md;
        @(posedge clk);
        model_update(wv, wr, wd, mv, mr, md);
        @(negedge clk);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        logic        wv, mv;
        logic [4:0]  wr, mr;
        foreach (d_rf[i]) d_rf[i] = '0;

        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wb_valid = 1'($urandom); wb_rd = 5'($urandom); wb_data = $urandom;
            mc_valid = 1'($urandom); mc_rd = 5'($urandom); mc_data = $urandom;
            @(negedge clk);
            check_zero("reset");
        end
        rst = 1'b1;
        idle("idle0");
        idle("idle1");

        step("arb0", 1'b1, 5'd5, 32'hAAAA, 1'b1, 5'd6, 32'hBBBB);
        idle("arb1");
        chk("arb1.pend6", {31'd0, pending[6]}, 32'd0);
        idle("arb2");

        step("byp0", 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h1234);
        idle("byp1");
        idle("byp2");

        step("kill0", 1'b1, 5'd1, 32'h11, 1'b1, 5'd9, 32'h1);
        chk("kill0.pend9", {31'd0, pending[9]}, 32'd1);
        step("kill1", 1'b1, 5'd9, 32'h2, 1'b0, 5'd0, 32'd0);
        idle("kill2");
        idle("kill3");
        idle("kill4");
        chk("kill.rf9", d_rf[9], 32'h2);

        step("full0", 1'b1, 5'd1, 32'h10, 1'b1, 5'd2, 32'h20);
        step("full1", 1'b1, 5'd1, 32'h11, 1'b1, 5'd3, 32'h30);
        chk("full2.ready", {31'd0, mc_ready}, 32'd0);
        step("full2", 1'b1, 5'd1, 32'h12, 1'b1, 5'd4, 32'h40);
        for (int i = 0; i < 3; i++) step("full3", 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h40);
        idle("full4");
        idle("full5");

        step("rd0a", 1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'd0);
        step("rd0b", 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hBEEF);
        idle("rd0c");
        idle("rd0d");

`ifdef RF_SCHED_STALL_EN
        step("stv0", 1'b1, 5'd1, 32'h1, 1'b1, 5'd20, 32'h2020);
        for (int i = 0; i < LIMIT; i++) step("stv1", 1'b1, 5'd1, 32'(i), 1'b0, 5'd0, 32'd0);
        chk("stv.hold1", {31'd0, wb_hold}, 32'd1);
        idle("stv2");
        chk("stv.hold0", {31'd0, wb_hold}, 32'd0);
        chk("stv.rd20", {27'd0, rd}, 32'd20);
        idle("stv3");
`endif

        for (int i = 0; i < 400; i++) begin
            wv = ($urandom_range(0, 9) < 6) && !e_hold;
            mv = 1'($urandom);
            wr = 5'($urandom_range(0, 7));
            mr = 5'($urandom_range(0, 7));
            step("rand", wv, wr, $urandom, mv, mr, $urandom);
        end
        for (int i = 0; i < 4; i++) idle("rdrain");

        step("ar0", 1'b1, 5'd1, 32'h5, 1'b1, 5'd10, 32'hA0);
        step("ar1", 1'b1, 5'd1, 32'h6, 1'b1, 5'd11, 32'hB0);
        chk("ar.pend", pending, 32'h0000_0C00);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_zero("arst");
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            step("arlow", 1'($urandom), 5'($urandom), $urandom, 1'($urandom), 5'($urandom),
                 $urandom);
        end
        rst = 1'b1;
        for (int i = 0; i < 5; i++) idle("arpost");
        check_zero("arend");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
